// File: rtl/tva_prec_pkg.sv
// Shared precision definitions for the attention A*V path.
// Used by token_precision_assigner and by the A*V multiplier that consumes
// its per-column precision selection.
//   prec_t        : 2-bit precision code (INT4 / INT8 / FP16)
//   CYCLES_*      : multiplier compute cycles per tile for each precision
package tva_prec_pkg;

  typedef enum logic [1:0] {
    PREC_INT4 = 2'b00,
    PREC_INT8 = 2'b01,
    PREC_FP16 = 2'b10
  } prec_t;

  localparam int CYCLES_INT4 = 1;
  localparam int CYCLES_INT8 = 2;
  localparam int CYCLES_FP16 = 4;

endpackage

// File: rtl/token_precision_assigner_prec_classifier.sv
// prec_classifier: combinational attention-mass classifier.
// Compares an unsigned column sum against two thresholds. The FP16 test has
// priority, so an INT8 threshold above the FP16 threshold still yields FP16
// whenever the FP16 test passes.
// Ports:
//   sum_i      : column attention sum (unsigned)
//   thr_int8_i : sum >= this selects at least INT8
//   thr_fp16_i : sum >= this selects FP16
//   prec_o     : resulting precision code
module prec_classifier
  import tva_prec_pkg::*;
#(
  parameter int SUM_W = 19
) (
  input  logic [SUM_W-1:0] sum_i,
  input  logic [SUM_W-1:0] thr_int8_i,
  input  logic [SUM_W-1:0] thr_fp16_i,
  output prec_t            prec_o
);

  always_comb begin
    prec_o = PREC_INT4;
    if (sum_i >= thr_fp16_i) begin
      prec_o = PREC_FP16;
    end else if (sum_i >= thr_int8_i) begin
      prec_o = PREC_INT8;
    end
  end

endmodule

// File: rtl/token_precision_assigner.sv
// token_precision_assigner: streams a post-softmax attention matrix column by
// column, sums each column and classifies the matching key/value token as
// INT4, INT8 or FP16 for the downstream A*V multiplier.
// Ports:
//   clk, rst          : clock; asynchronous active-high reset
//   start             : begin a run (only honoured in IDLE)
//   thr_int8/thr_fp16 : classification thresholds, latched at start
//   a_valid/a_ready   : beat handshake, a_data column-major unsigned Q1.15
//   precision_sel     : per-column precision code, stable while sel_valid=1
//   sel_valid         : high from done until the next accepted start
//   done              : one-cycle pulse after the last column is classified
// Optional build macro PREC_STATS_EN adds cnt_int4/cnt_int8/cnt_fp16 and
// est_cycles (multiplier compute-cycle estimate per tile).
module token_precision_assigner
  import tva_prec_pkg::*;
#(
  parameter int A_ROWS   = 8,
  parameter int NUM_COLS = 8,
  parameter int WIDTH    = 16,
  parameter int SUM_W    = WIDTH + $clog2(A_ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] thr_int8,
  input  logic [SUM_W-1:0] thr_fp16,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  output logic [1:0]       precision_sel [NUM_COLS],
  output logic             sel_valid,
  output logic             done
`ifdef PREC_STATS_EN
  ,
  output logic [$clog2(NUM_COLS+1)-1:0] cnt_int4,
  output logic [$clog2(NUM_COLS+1)-1:0] cnt_int8,
  output logic [$clog2(NUM_COLS+1)-1:0] cnt_fp16,
  output logic [15:0]                   est_cycles
`endif
);

  localparam int ROW_W = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_CLASSIFY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [SUM_W-1:0] thr_int8_q, thr_int8_d;
  logic [SUM_W-1:0] thr_fp16_q, thr_fp16_d;
  logic [1:0]       sel_q [NUM_COLS];
  logic [1:0]       sel_d [NUM_COLS];
  logic             sel_valid_q, sel_valid_d;
  prec_t            cls_prec;

`ifdef PREC_STATS_EN
  localparam int CNT_W = $clog2(NUM_COLS+1);
  logic [CNT_W-1:0] cnt_int4_q, cnt_int4_d;
  logic [CNT_W-1:0] cnt_int8_q, cnt_int8_d;
  logic [CNT_W-1:0] cnt_fp16_q, cnt_fp16_d;
  logic [15:0]      est_q, est_d;
`endif

  // Classification always uses the thresholds captured at start.
  prec_classifier #(.SUM_W(SUM_W)) u_cls (
    .sum_i      (sum_q),
    .thr_int8_i (thr_int8_q),
    .thr_fp16_i (thr_fp16_q),
    .prec_o     (cls_prec)
  );

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    row_d       = row_q;
    col_d       = col_q;
    thr_int8_d  = thr_int8_q;
    thr_fp16_d  = thr_fp16_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    a_ready     = 1'b0;
    done        = 1'b0;
`ifdef PREC_STATS_EN
    cnt_int4_d  = cnt_int4_q;
    cnt_int8_d  = cnt_int8_q;
    cnt_fp16_d  = cnt_fp16_q;
    est_d       = est_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          thr_int8_d  = thr_int8;
          thr_fp16_d  = thr_fp16;
          for (int i = 0; i < NUM_COLS; i++) sel_d[i] = PREC_FP16;
          sel_valid_d = 1'b0;
          sum_d       = '0;
          row_d       = '0;
          col_d       = '0;
`ifdef PREC_STATS_EN
          cnt_int4_d  = '0;
          cnt_int8_d  = '0;
          cnt_fp16_d  = '0;
          est_d       = '0;
`endif
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        a_ready = 1'b1;
        if (a_valid) begin
          // Sum width covers A_ROWS full-scale beats, so no saturation.
          sum_d = sum_q + SUM_W'(a_data);
          row_d = row_q + ROW_W'(1);
          if (row_q == ROW_W'(A_ROWS-1)) state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        sel_d[col_q] = cls_prec;
        sum_d        = '0;
        row_d        = '0;
`ifdef PREC_STATS_EN
        case (cls_prec)
          PREC_INT4: begin
            cnt_int4_d = cnt_int4_q + CNT_W'(1);
            est_d      = est_q + 16'(CYCLES_INT4);
          end
          PREC_INT8: begin
            cnt_int8_d = cnt_int8_q + CNT_W'(1);
            est_d      = est_q + 16'(CYCLES_INT8);
          end
          default: begin
            cnt_fp16_d = cnt_fp16_q + CNT_W'(1);
            est_d      = est_q + 16'(CYCLES_FP16);
          end
        endcase
`endif
        if (col_q == COL_W'(NUM_COLS-1)) begin
          state_d = S_DONE;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        sel_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      thr_int8_q  <= '0;
      thr_fp16_q  <= '0;
      sel_valid_q <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) sel_q[i] <= PREC_FP16;
`ifdef PREC_STATS_EN
      cnt_int4_q  <= '0;
      cnt_int8_q  <= '0;
      cnt_fp16_q  <= '0;
      est_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      row_q       <= row_d;
      col_q       <= col_d;
      thr_int8_q  <= thr_int8_d;
      thr_fp16_q  <= thr_fp16_d;
      sel_valid_q <= sel_valid_d;
      sel_q       <= sel_d;
`ifdef PREC_STATS_EN
      cnt_int4_q  <= cnt_int4_d;
      cnt_int8_q  <= cnt_int8_d;
      cnt_fp16_q  <= cnt_fp16_d;
      est_q       <= est_d;
`endif
    end
  end

  assign precision_sel = sel_q;
  assign sel_valid     = sel_valid_q;
`ifdef PREC_STATS_EN
  assign cnt_int4      = cnt_int4_q;
  assign cnt_int8      = cnt_int8_q;
  assign cnt_fp16      = cnt_fp16_q;
  assign est_cycles    = est_q;
`endif

endmodule

// File: tb/tb_token_precision_assigner.sv
// Directed bench for token_precision_assigner (8x8, 16-bit elements).
// With PREC_STATS_EN defined the statistics outputs are connected and checked.
module tb_token_precision_assigner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [18:0] thr_int8;
  logic [18:0] thr_fp16;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] a_data;
  logic [1:0]  psel [8];
  logic        sel_valid;
  logic        done;
`ifdef PREC_STATS_EN
  logic [3:0]  cnt_int4;
  logic [3:0]  cnt_int8;
  logic [3:0]  cnt_fp16;
  logic [15:0] est_cycles;
`endif

  logic [15:0] vec [64];
  logic [1:0]  exp_sel [8];
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  token_precision_assigner dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .thr_int8      (thr_int8),
    .thr_fp16      (thr_fp16),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_data        (a_data),
    .precision_sel (psel),
    .sel_valid     (sel_valid),
    .done          (done)
`ifdef PREC_STATS_EN
    ,
    .cnt_int4      (cnt_int4),
    .cnt_int8      (cnt_int8),
    .cnt_fp16      (cnt_fp16),
    .est_cycles    (est_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] pack_sel();
    logic [15:0] p;
    for (int i = 0; i < 8; i++) p[2*i +: 2] = psel[i];
    return p;
  endfunction

  task automatic set_col(input int c, input logic [15:0] v);
    for (int r = 0; r < 8; r++) vec[c*8 + r] = v;
  endtask

  task automatic set_exp(input logic [1:0] e0, e1, e2, e3, e4, e5, e6, e7);
    exp_sel[0] = e0; exp_sel[1] = e1; exp_sel[2] = e2; exp_sel[3] = e3;
    exp_sel[4] = e4; exp_sel[5] = e5; exp_sel[6] = e6; exp_sel[7] = e7;
  endtask

  // Waits (bounded) for a cycle in which a_ready is high, then lets that edge pass.
  task automatic wait_ready_edge(output bit timed_out);
    int g = 0;
    @(negedge clk);
    while (!a_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    timed_out = !a_ready;
    @(posedge clk);
    #1;
  endtask

  // One full run. Called 1 time unit after a rising edge.
  task automatic run(input bit bubbled, input bit midrun, input int exp_cyc, input string tag);
    int cyc = 0;
    int rdy = 0;
    bit seen = 0;
    bit rdy_at_done = 1'b1;
    bit to_any = 0;
    start   = 1'b1;
    a_valid = !bubbled;
    a_data  = vec[0];
    fork
      begin
        bit to;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int b = 0; b < 64; b++) begin
          if (bubbled) begin
            a_valid = 1'b0;
            wait_ready_edge(to);
            to_any |= to;
          end
          a_valid = 1'b1;
          a_data  = vec[b];
          if (midrun && b == 10) begin
            start    = 1'b1;
            thr_int8 = 19'h00000;
            thr_fp16 = 19'h00000;
          end
          wait_ready_edge(to);
          to_any |= to;
          start = 1'b0;
        end
        a_valid = 1'b0;
      end
      begin
        while (cyc < 400 && !seen) begin
          @(posedge clk);
          #2;
          cyc++;
          if (a_ready) rdy++;
          if (done) begin
            seen        = 1'b1;
            rdy_at_done = a_ready;
          end
        end
      end
    join
    chk({tag, " beat_timeout"}, 32'(to_any), 32'd0);
    chk({tag, " done_cycle"}, cyc, exp_cyc);
    chk({tag, " ready_cycles"}, rdy, bubbled ? 128 : 64);
    chk({tag, " ready_in_done"}, 32'(rdy_at_done), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, " sel_valid"}, 32'(sel_valid), 32'd1);
    chk({tag, " ready_idle"}, 32'(a_ready), 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s sel[%0d]", tag, i), 32'(psel[i]), 32'(exp_sel[i]));
  endtask

  task automatic scen1_data();
    set_col(0, 16'h0000);
    set_col(1, 16'h1000);
    set_col(2, 16'h4000);
    for (int c = 3; c < 8; c++) set_col(c, 16'h0800);
    set_exp(2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; a_data = '0;
    thr_int8 = '0; thr_fp16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sel", 32'(pack_sel()), 32'h0000AAAA);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sel_valid", 32'(sel_valid), 32'd0);
    chk("reset ready", 32'(a_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal mixed columns, continuous beats.
    thr_int8 = 19'h04000; thr_fp16 = 19'h10000;
    scen1_data();
    run(1'b0, 1'b0, 73, "nominal");
`ifdef PREC_STATS_EN
    chk("stats cnt_int4", 32'(cnt_int4), 32'd1);
    chk("stats cnt_int8", 32'(cnt_int8), 32'd6);
    chk("stats cnt_fp16", 32'(cnt_fp16), 32'd1);
    chk("stats est_cycles", 32'(est_cycles), 32'd17);
`endif

    // Same data with a bubble before every beat.
    run(1'b1, 1'b0, 137, "bubbled");

    // Exact threshold boundaries.
    for (int r = 0; r < 8; r++) vec[r] = 16'h0800;          // 0x04000
    for (int r = 0; r < 7; r++) vec[8 + r] = 16'h0800;
    vec[15] = 16'h07FF;                                     // 0x03FFF
    set_col(2, 16'h2000);                                   // 0x10000
    for (int r = 0; r < 7; r++) vec[24 + r] = 16'h2000;
    vec[31] = 16'h1FFF;                                     // 0x0FFFF
    set_col(4, 16'h0000);
    set_col(5, 16'hFFFF);                                   // 0x7FFF8
    set_col(6, 16'h1000);                                   // 0x08000
    set_col(7, 16'h0800);                                   // 0x04000
    set_exp(2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01);
    run(1'b0, 1'b0, 73, "boundary");

    // INT8 threshold above FP16 threshold: FP16 test wins.
    thr_int8 = 19'h10000; thr_fp16 = 19'h04000;
    set_exp(2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10);
    run(1'b0, 1'b0, 73, "inverted_thr");

    // start pulse and threshold change in the middle of a run.
    thr_int8 = 19'h04000; thr_fp16 = 19'h10000;
    scen1_data();
    run(1'b0, 1'b1, 73, "midrun_start");

    // Reset after 20 accepted beats.
    thr_int8 = 19'h04000; thr_fp16 = 19'h10000;
    start = 1'b1; a_valid = 1'b1; a_data = 16'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("midreset sel", 32'(pack_sel()), 32'h0000AAAA);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset sel_valid", 32'(sel_valid), 32'd0);
    chk("midreset ready", 32'(a_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; a_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) set_col(c, 16'hFFFF);
    set_exp(2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10);
    run(1'b0, 1'b0, 73, "after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
